mult_scheduler: RTL and testbench

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler.sv | 146 ++++++++++++++
 tb/tb_mult_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_scheduler.sv
// Two-client round-robin front end for a sequential 8x8 signed multiplier: LOAD -> SETTLE -> RUN -> RELEASE.
// Define MULT_SCHED_TIMEOUT_EN to add a RUN-state watchdog that aborts with rsp_err after TIMEOUT_CYCLES.
module mult_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 31
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  req,
    input  logic [7:0]  s0,
    input  logic [7:0]  b0,
    input  logic [7:0]  s1,
    input  logic [7:0]  b1,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  mult_sw,
    output logic        mult_clr_ld,
    output logic        mult_run,
    input  logic        mult_done,
    input  logic [15:0] mult_result
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mult_scheduler: TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state;
    logic        hold;
    logic        last;
    logic        idx;
    logic        win;
    logic        gnt_ok;
    logic [7:0]  s_q;
    logic [7:0]  b_q;
    logic [15:0] data_q;

    // Round-robin: a lone requester wins, otherwise the client not served last.
    always_comb begin
        win = ~last;
        if (req == 2'b01)
            win = 1'b0;
        else if (req == 2'b10)
            win = 1'b1;
    end

    // hold masks gnt in the first cycle after Reset so every output reads 0 there.
    assign gnt_ok = (state == IDLE) && !hold && !Reset && (req != 2'b00);
    assign gnt    = gnt_ok ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign busy        = (state != IDLE);
    assign mult_clr_ld = (state == LOAD);
    assign mult_run    = (state == RUN);
    assign rsp_valid   = (state == RELEASE) ? (idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data    = data_q;

    always_comb begin
        mult_sw = 8'h00;
        case (state)
            LOAD:        mult_sw = b_q;
            SETTLE, RUN: mult_sw = s_q;
            default:     mult_sw = 8'h00;
        endcase
    end

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q;

    assign cnt_inc = cnt + CNT_W'(1);
    assign rsp_err = err_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            cnt <= '0;
        else if (state == SETTLE)
            cnt <= '0;
        else if (state == RUN)
            cnt <= cnt_inc;
    end
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            hold   <= 1'b1;
            last   <= 1'b1;
            idx    <= 1'b0;
            s_q    <= 8'h00;
            b_q    <= 8'h00;
            data_q <= 16'h0000;
`ifdef MULT_SCHED_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
        end else begin
            hold <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        idx   <= win;
                        s_q   <= win ? s1 : s0;
                        b_q   <= win ? b1 : b0;
                        state <= LOAD;
                    end
                end
                LOAD:   state <= SETTLE;
                SETTLE: state <= RUN;
                RUN: begin
                    // A done arriving on the watchdog's last cycle still delivers the product.
                    if (mult_done) begin
                        data_q <= mult_result;
`ifdef MULT_SCHED_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                        state  <= RELEASE;
                    end
`ifdef MULT_SCHED_TIMEOUT_EN
                    else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        data_q <= 16'h0000;
                        err_q  <= 1'b1;
                        state  <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    last  <= idx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a behavioural sequential-multiplier stub.
// Timeout steps are compiled in only when MULT_SCHED_TIMEOUT_EN is defined.
module tb_mult_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  req;
    logic [7:0]  s0, b0, s1, b1;
    logic [1:0]  gnt;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  mult_sw;
    logic        mult_clr_ld;
    logic        mult_run;
    logic        mult_done;
    logic [15:0] mult_result;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Multiplier stub: loads B on ClearA_LoadB, raises done 18 cycles into Run, drops it when Run falls.
    logic [7:0]  m_b = 8'h00;
    logic [15:0] m_res = 16'h0000;
    logic        m_done_q = 1'b0;
    int          m_cnt = 0;
    logic        done_force = 1'b0;
    logic        done_block = 1'b0;

    always #5 Clk = ~Clk;

    mult_scheduler #(.TIMEOUT_CYCLES(31)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req         (req),
        .s0          (s0),
        .b0          (b0),
        .s1          (s1),
        .b1          (b1),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mult_sw     (mult_sw),
        .mult_clr_ld (mult_clr_ld),
        .mult_run    (mult_run),
        .mult_done   (mult_done),
        .mult_result (mult_result)
    );

    always @(posedge Clk) begin
        if (mult_clr_ld) begin
            m_b      <= mult_sw;
            m_done_q <= 1'b0;
            m_cnt    <= 0;
        end else if (!mult_run) begin
            m_done_q <= 1'b0;
            m_cnt    <= 0;
        end else if (!m_done_q) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == 18 && !done_block) begin
                m_done_q <= 1'b1;
                m_res    <= $signed(m_b) * $signed(mult_sw);
            end
        end
    end

    assign mult_done   = m_done_q | done_force;
    assign mult_result = m_res;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            check("no_overlap", 16'(mult_clr_ld & mult_run), 16'h0);
            if (!busy || rsp_valid != 2'b00)
                check("sw_zero", 16'(mult_sw), 16'h0);
        end
    end

    initial begin
        int n;
        int gseen;
        Reset = 1'b1; req = 2'b00;
        s0 = 8'h00; b0 = 8'h00; s1 = 8'h00; b1 = 8'h00;
        tick(); tick();
        mon_en = 1'b1;
        check("rst_gnt",   16'(gnt), 16'h0);
        check("rst_valid", 16'(rsp_valid), 16'h0);
        check("rst_data",  rsp_data, 16'h0);
        check("rst_err",   16'(rsp_err), 16'h0);
        check("rst_busy",  16'(busy), 16'h0);
        check("rst_sw",    16'(mult_sw), 16'h0);
        check("rst_clrld", 16'(mult_clr_ld), 16'h0);
        check("rst_run",   16'(mult_run), 16'h0);

        // Client 0: 7 * 3, operands disturbed after grant
        Reset = 1'b0; req = 2'b01; s0 = 8'h07; b0 = 8'h03;
        tick();
        check("t1_gnt", 16'(gnt), 16'h1);
        tick();
        req = 2'b00; s0 = 8'h55; b0 = 8'h11;
        check("t1_load_clr", 16'(mult_clr_ld), 16'h1);
        check("t1_load_sw",  16'(mult_sw), 16'h03);
        check("t1_load_run", 16'(mult_run), 16'h0);
        check("t1_load_gnt", 16'(gnt), 16'h0);
        tick();
        check("t1_settle_sw",  16'(mult_sw), 16'h07);
        check("t1_settle_clr", 16'(mult_clr_ld), 16'h0);
        check("t1_settle_run", 16'(mult_run), 16'h0);
        tick();
        check("t1_run",    16'(mult_run), 16'h1);
        check("t1_run_sw", 16'(mult_sw), 16'h07);
        n = 0;
        while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
        check("t1_latency", 16'(n), 16'd19);
        check("t1_valid", 16'(rsp_valid), 16'h1);
        check("t1_data",  rsp_data, 16'h0015);
        check("t1_err",   16'(rsp_err), 16'h0);
        check("t1_rel_run", 16'(mult_run), 16'h0);
        tick();
        check("t1_idle_busy",  16'(busy), 16'h0);
        check("t1_idle_valid", 16'(rsp_valid), 16'h0);

        // Client 1: -2 * 3
        req = 2'b10; s1 = 8'hFE; b1 = 8'h03;
        #1;
        check("t2_gnt", 16'(gnt), 16'h2);
        tick(); req = 2'b00; tick(); tick();
        check("t2_run_sw", 16'(mult_sw), 16'hFE);
        n = 0;
        while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
        check("t2_latency", 16'(n), 16'd19);
        check("t2_valid", 16'(rsp_valid), 16'h2);
        check("t2_data",  rsp_data, 16'hFFFA);
        tick();

        // Both clients from reset: round-robin and hold-off while busy
        Reset = 1'b1; tick();
        Reset = 1'b0; req = 2'b11;
        s0 = 8'h02; b0 = 8'h05; s1 = 8'h03; b1 = 8'hFD;
        #1;
        check("t3_hold_gnt",  16'(gnt), 16'h0);
        check("t3_hold_busy", 16'(busy), 16'h0);
        check("t3_hold_data", rsp_data, 16'h0);
        tick();
        check("t3_gnt0", 16'(gnt), 16'h1);
        tick();
        req = 2'b10;
        check("t3_load_gnt", 16'(gnt), 16'h0);
        n = 0; gseen = 0;
        while (rsp_valid == 2'b00 && n < 100) begin
            if (gnt != 2'b00) gseen++;
            tick(); n++;
        end
        check("t3_no_gnt_busy", 16'(gseen), 16'h0);
        check("t3_valid0", 16'(rsp_valid), 16'h1);
        check("t3_data0",  rsp_data, 16'h000A);
        req = 2'b11;
        tick();
        check("t3_gnt1", 16'(gnt), 16'h2);
        tick(); req = 2'b00; tick(); tick();
        n = 0;
        while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
        check("t3_valid1", 16'(rsp_valid), 16'h2);
        check("t3_data1",  rsp_data, 16'hFFF7);
        tick();

        // Reset on the 5th RUN cycle aborts the job
        req = 2'b01; s0 = 8'h07; b0 = 8'h03;
        #1;
        check("t4_gnt", 16'(gnt), 16'h1);
        tick(); req = 2'b00; tick(); tick();
        tick(); tick(); tick(); tick();
        check("t4_run5", 16'(mult_run), 16'h1);
        Reset = 1'b1;
        tick();
        check("t4_abort_busy",  16'(busy), 16'h0);
        check("t4_abort_run",   16'(mult_run), 16'h0);
        check("t4_abort_valid", 16'(rsp_valid), 16'h0);
        Reset = 1'b0; req = 2'b01;
        tick();
        check("t4_regnt", 16'(gnt), 16'h1);
        tick(); req = 2'b00; tick(); tick();
        n = 0;
        while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
        check("t4_latency", 16'(n), 16'd19);
        check("t4_data", rsp_data, 16'h0015);
        tick();

        // mult_done high outside RUN changes nothing
        done_force = 1'b1;
        tick(); tick();
        check("t5_idle_busy",  16'(busy), 16'h0);
        check("t5_idle_valid", 16'(rsp_valid), 16'h0);
        req = 2'b10; s1 = 8'h04; b1 = 8'h04;
        #1;
        check("t5_gnt", 16'(gnt), 16'h2);
        tick(); req = 2'b00;
        check("t5_load", 16'(mult_clr_ld), 16'h1);
        tick();
        check("t5_settle_run",  16'(mult_run), 16'h0);
        check("t5_settle_busy", 16'(busy), 16'h1);
        tick();
        check("t5_run", 16'(mult_run), 16'h1);
        tick();
        check("t5_valid", 16'(rsp_valid), 16'h2);
        done_force = 1'b0;
        tick();

`ifdef MULT_SCHED_TIMEOUT_EN
        // Watchdog: done never arrives
        done_block = 1'b1;
        req = 2'b01; s0 = 8'h07; b0 = 8'h03;
        #1;
        check("t6_gnt", 16'(gnt), 16'h1);
        tick(); req = 2'b00; tick(); tick();
        n = 0;
        while (rsp_valid == 2'b00 && n < 100) begin tick(); n++; end
        check("t6_latency", 16'(n), 16'd31);
        check("t6_valid", 16'(rsp_valid), 16'h1);
        check("t6_err",   16'(rsp_err), 16'h1);
        check("t6_data",  rsp_data, 16'h0000);
        done_block = 1'b0;
        tick();
`endif

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
